addsub_seq_ctrl: RTL

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit add/sub slice over WIDTH/4 cycles, LSB nibble first, with a registered inter-nibble carry. It sits between a requester issuing start/operands and the nibble ALU. It exposes a start/busy/done handshake and registered result and flags, so wide arithmetic reuses the existing 4-bit datapath instead of a wide adder.

---
 rtl/addsub_seq_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract sequenced over one 4-bit slice, LSB nibble first.
// Optional ADDSUB_SEQ_SAT_EN: saturate the result to the signed extreme on overflow.
module addsub_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             carry_out
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("addsub_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovfl_q, ovfl_d;
  logic             carry_out_q, carry_out_d;

  logic [3:0] nib_a, nib_b;
  logic [4:0] nib_sum;
  logic       c_msb_in;

  // Nibble slice; carry into bit 3 recovered from the sum bit to avoid a second adder.
  always_comb begin
    nib_a    = a_q[{cnt_q, 2'b00} +: 4];
    nib_b    = b_q[{cnt_q, 2'b00} +: 4];
    nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
    c_msb_in = nib_a[3] ^ nib_b[3] ^ nib_sum[3];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    shadow_d    = shadow_q;
    result_d    = result_q;
    ovfl_d      = ovfl_q;
    carry_out_d = carry_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          // Subtraction is A + ~B + 1: invert B here, seed the carry with sub.
          b_d     = b ^ {WIDTH{sub}};
          cnt_d   = '0;
          carry_d = sub;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        shadow_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = StDone;
          result_d    = shadow_d;
          carry_out_d = nib_sum[4];
          ovfl_d      = c_msb_in ^ nib_sum[4];
`ifdef ADDSUB_SEQ_SAT_EN
          if (c_msb_in ^ nib_sum[4]) begin
            result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      shadow_q    <= '0;
      result_q    <= '0;
      ovfl_q      <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      ovfl_q      <= ovfl_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign ovfl      = ovfl_q;
  assign carry_out = carry_out_q;

endmodule
